// File: rtl/hazard_stall_sequencer.sv
// Stall/flush controller for the 5-stage pipeline: merges load-use, data-memory wait and
// taken-branch hazards into the pipeline write enables, and counts stalled cycles.
module hazard_stall_sequencer #(
  parameter int REG_ADDR_W   = 5,
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  idExMemRead,
  input  logic [REG_ADDR_W-1:0] idExRt,
  input  logic [REG_ADDR_W-1:0] ifIdRs,
  input  logic [REG_ADDR_W-1:0] ifIdRt,
  input  logic                  exMemMemAccess,
  input  logic                  dmemReady,
  input  logic                  branchTaken,
  output logic                  pcWrite,
  output logic                  ifWrite,
  output logic                  resetIdControl,
  output logic                  flushIfId,
  output logic                  pipeFreeze,
  output logic                  memTimeout,
  output logic [CNT_W-1:0]      stallCycles
);

  localparam int WAIT_W  = $clog2(MEM_TIMEOUT + 1);
  localparam int FLUSH_W = $clog2(FLUSH_CYCLES + 1);
  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [FLUSH_W-1:0] FLUSH_ONE  = FLUSH_W'(1);

  typedef enum logic [1:0] {
    RUN,
    MEMWAIT,
    FLUSH
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WAIT_W-1:0]  wait_cnt_next;
  logic [FLUSH_W-1:0] flush_cnt;
  logic [FLUSH_W-1:0] flush_cnt_next;
  logic               timeout_set;
  logic               load_use;
  logic               mem_busy;

  // A load into r0 never creates a real dependency, so it must not stall.
  assign load_use = idExMemRead && (idExRt != '0) &&
                    ((idExRt == ifIdRs) || (idExRt == ifIdRt));
  assign mem_busy = exMemMemAccess && !dmemReady;

  always_comb begin
    pcWrite        = 1'b1;
    ifWrite        = 1'b1;
    resetIdControl = 1'b0;
    flushIfId      = 1'b0;
    pipeFreeze     = 1'b0;
    state_next     = state;
    wait_cnt_next  = wait_cnt;
    flush_cnt_next = flush_cnt;
    timeout_set    = 1'b0;

    if (!reset) begin
      case (state)
        RUN: begin
          if (mem_busy) begin
            pcWrite       = 1'b0;
            ifWrite       = 1'b0;
            pipeFreeze    = 1'b1;
            state_next    = MEMWAIT;
            wait_cnt_next = WAIT_ONE;
          end else if (branchTaken) begin
            flushIfId      = 1'b1;
            resetIdControl = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_next     = FLUSH;
              flush_cnt_next = FLUSH_INIT;
            end
          end else if (load_use) begin
            pcWrite        = 1'b0;
            ifWrite        = 1'b0;
            resetIdControl = 1'b1;
          end
        end

        // Branch and load-use are held in place by the freeze and re-evaluated in RUN.
        MEMWAIT: begin
          if (dmemReady) begin
            state_next = RUN;
          end else begin
            pcWrite    = 1'b0;
            ifWrite    = 1'b0;
            pipeFreeze = 1'b1;
            if (wait_cnt == WAIT_MAX) begin
              timeout_set = 1'b1;
              state_next  = RUN;
            end else begin
              wait_cnt_next = wait_cnt + WAIT_ONE;
            end
          end
        end

        FLUSH: begin
          if (mem_busy) begin
            pcWrite       = 1'b0;
            ifWrite       = 1'b0;
            pipeFreeze    = 1'b1;
            state_next    = MEMWAIT;
            wait_cnt_next = WAIT_ONE;
          end else begin
            flushIfId      = 1'b1;
            resetIdControl = 1'b1;
            flush_cnt_next = flush_cnt - FLUSH_ONE;
            if (flush_cnt == FLUSH_ONE) begin
              state_next = RUN;
            end
          end
        end

        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      flush_cnt   <= '0;
      memTimeout  <= 1'b0;
      stallCycles <= '0;
    end else begin
      state     <= state_next;
      wait_cnt  <= wait_cnt_next;
      flush_cnt <= flush_cnt_next;
      if (timeout_set) begin
        memTimeout <= 1'b1;
      end
      if (!pcWrite && (stallCycles != '1)) begin
        stallCycles <= stallCycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_sequencer.sv
// Directed bench for hazard_stall_sequencer: one input vector per cycle, driven on the
// falling edge, with outputs checked 1 ns later against hand-computed values.
module tb_hazard_stall_sequencer;

  localparam int REG_ADDR_W   = 5;
  localparam int MEM_TIMEOUT  = 16;
  localparam int FLUSH_CYCLES = 3;
  localparam int CNT_W        = 5;

  // {pcWrite, ifWrite, resetIdControl, flushIfId, pipeFreeze}
  localparam logic [4:0] O_IDLE   = 5'b11000;
  localparam logic [4:0] O_BUBBLE = 5'b00100;
  localparam logic [4:0] O_FLUSH  = 5'b11110;
  localparam logic [4:0] O_FREEZE = 5'b00001;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  idExMemRead;
  logic [REG_ADDR_W-1:0] idExRt;
  logic [REG_ADDR_W-1:0] ifIdRs;
  logic [REG_ADDR_W-1:0] ifIdRt;
  logic                  exMemMemAccess;
  logic                  dmemReady;
  logic                  branchTaken;
  logic                  pcWrite;
  logic                  ifWrite;
  logic                  resetIdControl;
  logic                  flushIfId;
  logic                  pipeFreeze;
  logic                  memTimeout;
  logic [CNT_W-1:0]      stallCycles;
  logic [4:0]            out_vec;

  int checks = 0;
  int errors = 0;

  hazard_stall_sequencer #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .idExMemRead   (idExMemRead),
    .idExRt        (idExRt),
    .ifIdRs        (ifIdRs),
    .ifIdRt        (ifIdRt),
    .exMemMemAccess(exMemMemAccess),
    .dmemReady     (dmemReady),
    .branchTaken   (branchTaken),
    .pcWrite       (pcWrite),
    .ifWrite       (ifWrite),
    .resetIdControl(resetIdControl),
    .flushIfId     (flushIfId),
    .pipeFreeze    (pipeFreeze),
    .memTimeout    (memTimeout),
    .stallCycles   (stallCycles)
  );

  assign out_vec = {pcWrite, ifWrite, resetIdControl, flushIfId, pipeFreeze};

  always #5 clk = ~clk;

  // One call per clock cycle: drive on the falling edge, settle 1 ns before checking.
  task automatic apply_stimulus(input logic rst, input logic mem_read,
                                input logic [REG_ADDR_W-1:0] ex_rt,
                                input logic [REG_ADDR_W-1:0] id_rs,
                                input logic [REG_ADDR_W-1:0] id_rt,
                                input logic access, input logic ready,
                                input logic branch);
    @(negedge clk);
    reset          = rst;
    idExMemRead    = mem_read;
    idExRt         = ex_rt;
    ifIdRs         = id_rs;
    ifIdRt         = id_rt;
    exMemMemAccess = access;
    dmemReady      = ready;
    branchTaken    = branch;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset          = 1'b1;
    idExMemRead    = 1'b0;
    idExRt         = '0;
    ifIdRs         = '0;
    ifIdRt         = '0;
    exMemMemAccess = 1'b0;
    dmemReady      = 1'b0;
    branchTaken    = 1'b0;

    // Reset forces idle outputs even with a load-use hazard and a busy memory present.
    apply_stimulus(1, 1, 8, 8, 0, 1, 0, 0);
    check_output("rst_outputs_forced", out_vec, O_IDLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rst_outputs_idle", out_vec, O_IDLE);
    check_output("rst_stall_cnt", stallCycles, 0);
    check_output("rst_mem_timeout", memTimeout, 0);

    // Load-use: rs match, then r0 (no stall), then rt match.
    apply_stimulus(0, 1, 8, 8, 0, 0, 0, 0);
    check_output("lu_rs_bubble", out_vec, O_BUBBLE);
    apply_stimulus(0, 1, 0, 0, 0, 0, 0, 0);
    check_output("lu_r0_no_stall", out_vec, O_IDLE);
    apply_stimulus(0, 1, 9, 3, 9, 0, 0, 0);
    check_output("lu_rt_bubble", out_vec, O_BUBBLE);
    apply_stimulus(0, 0, 9, 9, 9, 0, 0, 0);
    check_output("lu_no_memread", out_vec, O_IDLE);
    check_output("lu_stall_cnt", stallCycles, 2);

    apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rst2_stall_cnt", stallCycles, 0);

    // Memory wait of three cycles, released on dmemReady.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("mw_freeze0", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("mw_freeze1", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("mw_freeze2", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
    check_output("mw_release", out_vec, O_IDLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("mw_after_idle", out_vec, O_IDLE);
    check_output("mw_stall_cnt", stallCycles, 3);
    check_output("mw_no_timeout", memTimeout, 0);

    // Timeout: one RUN cycle plus 16 MEMWAIT cycles all frozen, then the pipe is released.
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
      check_output($sformatf("to_freeze%0d", i), out_vec, O_FREEZE);
      check_output($sformatf("to_flag_low%0d", i), memTimeout, 0);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("to_released", out_vec, O_IDLE);
    check_output("to_flag_set", memTimeout, 1);
    check_output("to_stall_cnt", stallCycles, 20);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
    check_output("to_flag_sticky", memTimeout, 1);

    // Branch wins over a simultaneous load-use and flushes for exactly three cycles.
    apply_stimulus(0, 1, 8, 8, 0, 0, 0, 1);
    check_output("br_flush0", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("br_flush1", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("br_flush2", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("br_done", out_vec, O_IDLE);
    check_output("br_stall_cnt", stallCycles, 20);

    // Busy memory beats a branch; the held branch flushes after dmemReady.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1);
    check_output("mb_freeze0", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 1);
    check_output("mb_freeze1", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 1);
    check_output("mb_ready_idle", out_vec, O_IDLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("mb_flush0", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("mb_flush1", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("mb_flush2", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("mb_done", out_vec, O_IDLE);
    check_output("mb_stall_cnt", stallCycles, 22);

    // Memory stall during FLUSH drops the remaining flush cycles.
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 1);
    check_output("fm_flush", out_vec, O_FLUSH);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("fm_freeze", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 1, 0);
    check_output("fm_ready", out_vec, O_IDLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("fm_flush_dropped", out_vec, O_IDLE);
    check_output("fm_stall_cnt", stallCycles, 23);

    // Another 17-cycle timed-out wait takes the 5-bit counter past 31; it must saturate.
    for (int i = 0; i < MEM_TIMEOUT + 1; i++) begin
      apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    end
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("sat_stall_cnt", stallCycles, 31);
    apply_stimulus(0, 1, 4, 4, 0, 0, 0, 0);
    check_output("sat_bubble", out_vec, O_BUBBLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("sat_hold", stallCycles, 31);

    // Reset in the middle of a memory wait abandons it and clears the sticky flag.
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("rmw_freeze0", out_vec, O_FREEZE);
    apply_stimulus(0, 0, 0, 0, 0, 1, 0, 0);
    check_output("rmw_freeze1", out_vec, O_FREEZE);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);
    check_output("rmw_forced_idle", out_vec, O_IDLE);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    check_output("rmw_state_run", out_vec, O_IDLE);
    check_output("rmw_stall_cnt", stallCycles, 0);
    check_output("rmw_mem_timeout", memTimeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
